// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - single-port VRAM arbiter between VGA scan-out and a buffered pixel writer
//
// Purpose:
//   Display scan-out owns the VRAM port whenever valid=1. Writer requests go
//   into a small FIFO and are drained one per cycle during blanking.
//   Display latency is fixed at 3 cycles from valid to pix_valid.
//
// Optional feature (macro VRAM_CLEAR_EN):
//   Adds parameter CLEAR_COLOR, input clear_req and output clear_busy. A
//   screen clear fills every pixel with CLEAR_COLOR during non-display cycles
//   and has priority over draining the FIFO.
//
// Ports:
//   pclk, reset              pixel clock, asynchronous active-high reset
//   valid, h_cnt, v_cnt      timing generator active-video flag and position
//   wr_req, wr_addr, wr_data writer request; transfers when wr_req & wr_ready
//   wr_ready                 FIFO not full
//   mem_addr/mem_we/mem_wdata registered VRAM control
//   mem_rdata                VRAM read data, one cycle after mem_addr
//   pix_data, pix_valid      registered pixel to the DAC
//   fifo_cnt                 current FIFO occupancy
//   clear_req, clear_busy    (VRAM_CLEAR_EN only) screen clear control/status
module vga_vram_arbiter #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 12,
    parameter int FIFO_AW = 2
`ifdef VRAM_CLEAR_EN
    ,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
`endif
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [9:0]           h_cnt,
    input  logic [9:0]           v_cnt,
    input  logic                 wr_req,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    pix_data,
    output logic                 pix_valid,
`ifdef VRAM_CLEAR_EN
    input  logic                 clear_req,
    output logic                 clear_busy,
`endif
    output logic [FIFO_AW:0]     fifo_cnt
);

    localparam int                FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  FULL_CNT   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [ADDR_W-1:0] H_RES_A    = ADDR_W'(H_RES);
    localparam logic [31:0]       PIX_TOTAL  = 32'(H_RES * V_RES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DISP  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t state_q, state_d;

    // write FIFO
    logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic               push, pop;

    // VRAM port and display pipeline
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               disp_d2_q;
    logic               pix_valid_q;
    logic [DATA_W-1:0]  pix_data_q;

    logic [ADDR_W-1:0]  pix_addr;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               head_in_range;

`ifdef VRAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES * V_RES - 1);
    logic               clear_busy_q, clear_busy_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
`endif

    assign wr_ready      = (fifo_cnt_q != FULL_CNT);
    assign push          = wr_req && wr_ready;
    assign pix_addr      = ADDR_W'(v_cnt) * H_RES_A + ADDR_W'(h_cnt);
    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign head_in_range = ({{(32-ADDR_W){1'b0}}, head_addr} < PIX_TOTAL);

    // State register
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next owner, decided from this cycle's inputs in priority order
    always_comb begin
        state_d = ST_IDLE;
        if (valid) begin
            state_d = ST_DISP;
`ifdef VRAM_CLEAR_EN
        end else if (clear_busy_q) begin
            state_d = ST_CLEAR;
`endif
        end else if (fifo_cnt_q != '0) begin
            state_d = ST_DRAIN;
        end
    end

    // Owner actions: what the VRAM port and FIFO do at the coming edge
    always_comb begin
        pop         = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_d)
            ST_DISP: begin
                mem_addr_d = pix_addr;
            end
            ST_DRAIN: begin
                pop = 1'b1;
                // Out-of-range entries are consumed without touching the port
                if (head_in_range) begin
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                    mem_we_d    = 1'b1;
                end
            end
`ifdef VRAM_CLEAR_EN
            ST_CLEAR: begin
                mem_addr_d  = clr_cnt_q;
                mem_wdata_d = CLEAR_COLOR;
                mem_we_d    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            disp_d2_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            // state_q==DISP marks the cycle mem_addr carries a display read;
            // mem_rdata for it arrives one cycle later, captured the next.
            disp_d2_q   <= (state_q == ST_DISP);
            pix_valid_q <= disp_d2_q;
            pix_data_q  <= disp_d2_q ? mem_rdata : '0;
        end
    end

`ifdef VRAM_CLEAR_EN
    always_comb begin
        clear_busy_d = clear_busy_q;
        clr_cnt_d    = clr_cnt_q;
        if (!clear_busy_q) begin
            if (clear_req) begin
                clear_busy_d = 1'b1;
                clr_cnt_d    = '0;
            end
        end else if (state_d == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
                clear_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            clear_busy_q <= 1'b0;
            clr_cnt_q    <= '0;
        end else begin
            clear_busy_q <= clear_busy_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    assign clear_busy = clear_busy_q;
`endif

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign fifo_cnt  = fifo_cnt_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb/tb_vga_vram_arbiter.sv - self-checking bench for vga_vram_arbiter
module tb_vga_vram_arbiter;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int PIX = H * V;
    localparam int MSZ = 1 << 19;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_ready;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic [2:0]  fifo_cnt;

    int total = 0;
    int bad   = 0;

    vga_vram_arbiter dut (
        .pclk      (pclk),
        .reset     (reset),
        .valid     (valid),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 pclk = ~pclk;

    function automatic logic [11:0] pattern(input int a);
        return 12'(a) ^ 12'h5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // VRAM macro: synchronous, read-first
    logic [11:0] ram [MSZ];
    always @(posedge pclk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    // Reference model: a queue for the FIFO, an image array, a 3-deep pixel delay
    typedef struct {
        logic [18:0] a;
        logic [11:0] d;
    } ent_t;

    logic [11:0] ref_mem [MSZ];
    ent_t        mq [$];
    logic [12:0] pipe [$];
    logic [18:0] exp_addr  = '0;
    logic        exp_we    = 1'b0;
    logic [11:0] exp_wdata = '0;
    logic [12:0] exp_pix   = '0;

    always @(posedge pclk or posedge reset) begin
        ent_t        e;
        int          sz;
        logic [12:0] nw;
        if (reset) begin
            exp_addr  = '0;
            exp_we    = 1'b0;
            exp_wdata = '0;
            mq.delete();
            pipe      = '{13'd0, 13'd0, 13'd0};
            exp_pix   = '0;
        end else begin
            sz     = mq.size();
            exp_we = 1'b0;
            nw     = '0;
            if (valid) begin
                exp_addr = 19'(int'(v_cnt) * H + int'(h_cnt));
                nw       = {1'b1, ref_mem[exp_addr]};
            end else if (sz > 0) begin
                e = mq.pop_front();
                if (int'(e.a) < PIX) begin
                    exp_addr   = e.a;
                    exp_wdata  = e.d;
                    exp_we     = 1'b1;
                    ref_mem[e.a] = e.d;
                end
            end
            if (wr_req && sz < 4) begin
                e.a = wr_addr;
                e.d = wr_data;
                mq.push_back(e);
            end
            pipe.push_back(nw);
            void'(pipe.pop_front());
            exp_pix = pipe[0];
        end
    end

    always @(negedge pclk) begin
        chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
        chk("mem_we",    32'(mem_we),    32'(exp_we));
        chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        chk("pix_valid", 32'(pix_valid), 32'(exp_pix[12]));
        chk("pix_data",  32'(pix_data),  32'(exp_pix[11:0]));
        chk("fifo_cnt",  32'(fifo_cnt),  32'(mq.size()));
        chk("wr_ready",  32'(wr_ready),  32'(mq.size() < 4));
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        logic        take;
        logic [18:0] got [$];
        int          wecnt;
        for (int i = 0; i < MSZ; i++) begin
            ram[i]     = pattern(i);
            ref_mem[i] = pattern(i);
        end
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        reset = 1'b0;
        step();

        // single display read of (5,2)
        valid = 1'b1; h_cnt = 10'd5; v_cnt = 10'd2;
        step();
        valid = 1'b0;
        chk("disp_addr_1285", 32'(mem_addr), 32'd1285);
        chk("disp_we0", 32'(mem_we), 32'd0);
        step();
        step();
        chk("pix_valid_1285", 32'(pix_valid), 32'd1);
        chk("pix_1285", 32'(pix_data), 32'h0A0);
        step();
        chk("pix_off_valid", 32'(pix_valid), 32'd0);
        chk("pix_off_data", 32'(pix_data), 32'd0);

        // blanking write of addr 100, then read back through display
        wr_req = 1'b1; wr_addr = 19'd100; wr_data = 12'hABC;
        step();
        wr_req = 1'b0;
        chk("push_cnt1", 32'(fifo_cnt), 32'd1);
        step();
        chk("wr100_we", 32'(mem_we), 32'd1);
        chk("wr100_addr", 32'(mem_addr), 32'd100);
        chk("wr100_data", 32'(mem_wdata), 32'hABC);
        step();
        step();
        valid = 1'b1; h_cnt = 10'd100; v_cnt = 10'd0;
        step();
        valid = 1'b0;
        step();
        step();
        chk("rd100_valid", 32'(pix_valid), 32'd1);
        chk("rd100_data", 32'(pix_data), 32'hABC);

        // five pushes during active video
        valid = 1'b1; v_cnt = 10'd3;
        for (int i = 0; i < 4; i++) begin
            h_cnt = 10'(i);
            wr_req = 1'b1; wr_addr = 19'(200 + i); wr_data = 12'(12'h100 + i);
            step();
        end
        h_cnt = 10'd4; wr_addr = 19'd204; wr_data = 12'h104;
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_cnt", 32'(fifo_cnt), 32'd4);
        chk("full_we", 32'(mem_we), 32'd0);
        for (int i = 5; i < 10; i++) begin
            h_cnt = 10'(i);
            step();
        end
        chk("full_ready_hold", 32'(wr_ready), 32'd0);
        chk("full_cnt_hold", 32'(fifo_cnt), 32'd4);
        valid = 1'b0;
        got.delete();
        for (int k = 0; k < 12; k++) begin
            take = wr_req && wr_ready;
            step();
            if (take) wr_req = 1'b0;
            if (mem_we) got.push_back(mem_addr);
        end
        chk("drain_count", 32'(got.size()), 32'd5);
        for (int j = 0; j < 5; j++) begin
            chk("drain_order", (j < got.size()) ? 32'(got[j]) : 32'hFFFFFFFF, 32'(200 + j));
        end
        wr_req = 1'b0;

        // out-of-range write is dropped
        wr_req = 1'b1; wr_addr = 19'd307200; wr_data = 12'h123;
        step();
        wr_req = 1'b0;
        step();
        step();
        chk("oor_we", 32'(mem_we), 32'd0);
        chk("oor_cnt", 32'(fifo_cnt), 32'd0);

        // short scan of row 1
        valid = 1'b1; v_cnt = 10'd1;
        for (int i = 0; i < 8; i++) begin
            h_cnt = 10'(i * 3 + 1);
            step();
        end
        valid = 1'b0;
        repeat (4) step();

        // asynchronous reset with three writes pending mid-line
        valid = 1'b1; v_cnt = 10'd4;
        for (int i = 0; i < 3; i++) begin
            h_cnt = 10'(i);
            wr_req = 1'b1; wr_addr = 19'(300 + i); wr_data = 12'(12'h200 + i);
            step();
        end
        wr_req = 1'b0; h_cnt = 10'd3;
        chk("pre_rst_cnt", 32'(fifo_cnt), 32'd3);
        chk("pre_rst_pixv", 32'(pix_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_wdata", 32'(mem_wdata), 32'd0);
        chk("arst_pixv", 32'(pix_valid), 32'd0);
        chk("arst_pix", 32'(pix_data), 32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd1);
        chk("arst_cnt", 32'(fifo_cnt), 32'd0);
        @(posedge pclk);
        @(posedge pclk);
        #1;
        valid = 1'b0;
        reset = 1'b0;
        wecnt = 0;
        repeat (10) begin
            step();
            if (mem_we) wecnt++;
        end
        chk("post_rst_no_write", 32'(wecnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
